uart_tx_arbiter: RTL and testbench

Round-robin arbiter sharing the single UART byte transmitter between up to N command sequencers (fill, pixel, text, status). It sits between the sequencers and the transmitter and grants the byte channel (txdata/ldtxdata/txempty) to one requester for a whole multi-byte command frame. Frames from different requesters never interleave. A watchdog revokes a grant when its owner stalls.

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART byte transmitter between N command
// sequencers. The winner keeps the byte channel for its whole frame, so frames
// from different requesters never interleave. A watchdog takes the channel back
// from an owner that stops loading bytes.
//
// Ports
//   clk, reset_n        clock (rising edge) / asynchronous active-low reset
//   req[N]              per-requester frame request, held high for the frame
//   src_txdata[8N]      byte from requester i at [8i+7:8i]
//   src_ldtxdata[N]     per-requester load strobe
//   txempty             transmitter ready for the next byte
//   txdata, ldtxdata    byte and load strobe to the transmitter (owner only)
//   grant[N]            registered one-hot grant
//   src_txempty[N]      txempty routed to the granted requester only
//   busy                channel owned or draining
//   timeout_err         one-cycle pulse when the watchdog revokes a grant
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] src_txdata,
  input  logic [N-1:0]   src_ldtxdata,
  input  logic           txempty,
  output logic [7:0]     txdata,
  output logic           ldtxdata,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   src_txempty,
  output logic           busy,
  output logic           timeout_err
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_DRAIN} state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [IW-1:0]   r_own;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic            r_tmo;

  logic [IW-1:0]   w_pick;
  logic            w_found;
  logic [7:0]      w_byte;
  logic            w_ld;
  logic            w_req_own;
  logic            w_expire;

  // Scan last+1, last+2, ... so the previous owner gets the lowest priority.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && req[(int'(r_last) + k) % N]) begin
        w_found = 1'b1;
        w_pick  = IW'((int'(r_last) + k) % N);
      end
    end
  end

  // The grant is only non-zero while owning, so gating by it alone
  // blanks the channel in IDLE and DRAIN.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) w_byte = src_txdata[8*i +: 8];
    end
  end

  assign w_ld      = |(r_grant & src_ldtxdata);
  assign w_req_own = |(r_grant & req);
  assign w_expire  = (r_cnt == CW'(TIMEOUT)) && !w_ld;

  assign txdata      = w_byte;
  assign ldtxdata    = w_ld;
  assign grant       = r_grant;
  assign src_txempty = r_grant & {N{txempty}};
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_tmo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_own   <= '0;
      r_last  <= IW'(N - 1);
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_OWN;
            r_grant <= {{(N-1){1'b0}}, 1'b1} << w_pick;
            r_own   <= w_pick;
            r_cnt   <= '0;
          end
        end
        S_OWN: begin
          // A dropped request wins over expiry: a normal frame end is no error.
          if (!w_req_own) begin
            r_state <= S_DRAIN;
            r_grant <= '0;
          end else if (w_expire) begin
            r_state <= S_DRAIN;
            r_grant <= '0;
            r_tmo   <= 1'b1;
          end else if (w_ld) begin
            r_cnt <= '0;
          end else begin
            // Never passes TIMEOUT: reaching it without a strobe expires.
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          // Let the last loaded byte leave before handing the channel over.
          if (txempty) begin
            r_state <= S_IDLE;
            r_last  <= r_own;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N=4, TIMEOUT=8): a hand-computed
// vector table, directed multi-cycle sequences, and random traffic, all also
// compared every cycle against a frame-level reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] src_txdata;
  logic [N-1:0]   src_ld;
  logic           txempty;
  logic [7:0]     txdata;
  logic           ldtxdata;
  logic [N-1:0]   grant;
  logic [N-1:0]   src_txempty;
  logic           busy;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .src_txdata(src_txdata),
    .src_ldtxdata(src_ld), .txempty(txempty), .txdata(txdata),
    .ldtxdata(ldtxdata), .grant(grant), .src_txempty(src_txempty),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the channel, whether it is draining, who owned
  // it last, and how long the owner has been silent.
  int m_owner;
  bit m_drain;
  int m_last;
  int m_quiet;
  bit m_tmo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit m_own();
    return (m_owner >= 0) && !m_drain;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_drain = 0; m_last = N - 1; m_quiet = 0; m_tmo = 0;
  endtask

  // Called right after each rising edge with the inputs the DUT just sampled.
  task automatic model_step();
    bit fwd;
    int idx;
    m_tmo = 0;
    if (!reset_n) return;
    if (m_own()) begin
      fwd = src_ld[m_owner];
      if (!req[m_owner]) m_drain = 1;
      else if (!fwd && m_quiet == TO) begin m_drain = 1; m_tmo = 1; end
      else if (fwd) m_quiet = 0;
      else m_quiet++;
    end else if (m_drain) begin
      if (txempty) begin m_last = m_owner; m_owner = -1; m_drain = 0; end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (m_owner < 0 && req[idx]) begin m_owner = idx; m_quiet = 0; end
      end
    end
  endtask

  task automatic model_check();
    logic [N-1:0] eg;
    eg = m_own() ? 4'(1 << m_owner) : 4'b0;
    chk("grant", grant, eg);
    if (m_own()) begin
      chk("txdata", txdata, src_txdata[8*m_owner +: 8]);
      chk("ldtxdata", ldtxdata, src_ld[m_owner]);
    end else begin
      chk("txdata", txdata, 0);
      chk("ldtxdata", ldtxdata, 0);
    end
    chk("src_txempty", src_txempty, txempty ? eg : 4'b0);
    chk("busy", busy, m_owner >= 0);
    chk("timeout_err", timeout_err, m_tmo);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    reset_n = 0; req = '0; src_ld = '0; src_txdata = '0; txempty = 1'b1;
    model_reset();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_ld", ldtxdata, 0);
    chk("rst_txdata", txdata, 0);
    chk("rst_stx", src_txempty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout_err, 0);
    tick(); tick();
    reset_n = 1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  ld;
    logic [31:0] data;
    logic        te;
    logic [3:0]  g;
    logic [7:0]  tx;
    logic        l;
    logic [3:0]  stx;
    logic        b;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //           req     ld      data          te    grant   tx     ld    stx     busy
    tbl[0] = '{4'b0100, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0};
    tbl[1] = '{4'b0100, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 8'hA5, 1'b1, 4'b0100, 1'b1};
    tbl[2] = '{4'b0100, 4'b1000, 32'h3C110000, 1'b1, 4'b0100, 8'h11, 1'b0, 4'b0100, 1'b1};
    tbl[3] = '{4'b0000, 4'b0100, 32'h00220000, 1'b0, 4'b0100, 8'h22, 1'b1, 4'b0000, 1'b1};
    tbl[4] = '{4'b0010, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b1};
    tbl[5] = '{4'b0010, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b1};
    tbl[6] = '{4'b0010, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b1};
    tbl[7] = '{4'b0010, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0};
    tbl[8] = '{4'b1010, 4'b1000, 32'h3C005A00, 1'b1, 4'b0010, 8'h5A, 1'b0, 4'b0010, 1'b1};

    // Single requester, combinational forwarding, drain, isolation.
    do_reset();
    settle();
    for (int i = 0; i < 9; i++) begin
      tick();
      req = tbl[i].req; src_ld = tbl[i].ld; src_txdata = tbl[i].data; txempty = tbl[i].te;
      settle();
      chk($sformatf("t%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("t%0d_txdata", i), txdata, tbl[i].tx);
      chk($sformatf("t%0d_ld", i), ldtxdata, tbl[i].l);
      chk($sformatf("t%0d_stx", i), src_txempty, tbl[i].stx);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].b);
    end

    // Fair rotation: every owner sends 6 bytes then drops req for one cycle.
    begin
      logic [3:0] gq[$];
      logic [3:0] pg;
      logic [3:0] exp_g[5];
      int sent;
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      pg = '0; sent = 0;
      do_reset();
      req = 4'hF;
      settle();
      for (int c = 0; c < 300 && gq.size() < 5; c++) begin
        tick();
        if (grant != 0 && pg == 0) gq.push_back(grant);
        pg = grant;
        req = 4'hF; src_ld = 4'hF;
        for (int i = 0; i < N; i++) src_txdata[8*i +: 8] = 8'hE0 | 8'(i);
        if (m_own()) begin
          if (sent == 6) begin
            req[m_owner] = 1'b0; src_ld = '0; sent = 0;
          end else begin
            src_txdata[8*m_owner +: 8] = 8'(16 * m_owner + sent);
            sent++;
          end
        end
        settle();
      end
      chk("rot_count", gq.size(), 5);
      for (int i = 0; i < 5; i++)
        chk($sformatf("rot_grant%0d", i), (i < gq.size()) ? gq[i] : 4'b0, exp_g[i]);
    end

    // DRAIN hold while txempty stays low, then a 2-cycle handover gap.
    do_reset();
    req = 4'b0001;
    settle();
    tick(); req = 4'b0011; settle();
    tick(); req = 4'b0010; txempty = 1'b0; settle();
    for (int i = 0; i < 5; i++) begin
      tick(); settle();
      chk("drain_busy", busy, 1);
      chk("drain_grant", grant, 0);
    end
    tick(); txempty = 1'b1; settle();
    tick(); settle(); chk("drain_gap", grant, 0);
    tick(); settle(); chk("drain_next", grant, 4'b0010);

    // Watchdog: silent owner 0 is revoked 9 cycles after its grant.
    begin
      int gk, tk, np;
      logic [3:0] g1, g2;
      gk = -1; tk = -1; np = 0; g1 = '0; g2 = '0;
      do_reset();
      req = 4'b0011;
      settle();
      for (int c = 0; c < 30; c++) begin
        tick(); settle();
        if (gk < 0 && grant != 0) begin gk = c; g1 = grant; end
        if (timeout_err && c <= 15) begin
          np++;
          if (tk < 0) begin tk = c; chk("wd_grant_drop", grant, 0); end
        end
        if (tk >= 0 && g2 == 0 && grant != 0) g2 = grant;
      end
      chk("wd_first", g1, 4'b0001);
      chk("wd_latency", tk - gk, 9);
      chk("wd_pulses", np, 1);
      chk("wd_next", g2, 4'b0010);
    end

    // Reset in the middle of a frame.
    do_reset();
    req = 4'b0100;
    settle();
    for (int b = 0; b < 3; b++) begin
      tick();
      src_ld = 4'b0100; src_txdata[23:16] = 8'(8'h40 + b);
      settle();
    end
    reset_n = 0;
    model_reset();
    #1;
    chk("rm_grant", grant, 0);
    chk("rm_ld", ldtxdata, 0);
    model_check();
    tick(); tick();
    reset_n = 1; req = 4'hF; src_ld = '0;
    settle();
    tick(); settle();
    chk("rm_prio", grant, 4'b0001);

    // Random traffic against the model; quiet stretches provoke timeouts.
    do_reset();
    settle();
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      src_ld     = 4'($urandom);
      src_txdata = $urandom;
      txempty    = ($urandom_range(0, 3) != 0);
      if (((c / 40) % 3) == 0) src_ld = '0;
      settle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
